// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator.
// Scans two captured operands MSB first, one bit per clock, and stops at the
// first differing bit. Signed mode inverts the decision at the sign bit only.
// The GT/LT/EQ result is registered and held until the next comparison ends.
module serial_mag_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             GT,
   output logic             LT,
   output logic             EQ
);

   localparam int IDX_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic             sgn_q,   sgn_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic             gt_q,    gt_d;
   logic             lt_q,    lt_d;
   logic             eq_q,    eq_d;

   logic             bit_a_s;
   logic             bit_b_s;
   logic             a_wins_s;

   // Next-state, capture and result decision for the scan FSM.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      sgn_d    = sgn_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      gt_d     = gt_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
      bit_a_s  = a_q[idx_q];
      bit_b_s  = b_q[idx_q];
      // At the sign bit of a signed compare, a set bit means the smaller value.
      a_wins_s = bit_a_s ^ (sgn_q & (idx_q == IDX_MSB));

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               sgn_d   = signed_mode;
               idx_d   = IDX_MSB;
               state_d = ST_SCAN;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         ST_SCAN: begin
            busy_d = 1'b1;
            if (bit_a_s != bit_b_s) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               gt_d    = a_wins_s;
               lt_d    = ~a_wins_s;
               eq_d    = 1'b0;
            end else if (idx_q == IDX_ZERO) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               eq_d    = 1'b1;
            end else begin
               idx_d   = idx_q - IDX_W'(1);
               state_d = ST_SCAN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset overrides any transition in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= IDX_ZERO;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         sgn_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign GT   = gt_q;
   assign LT   = lt_q;
   assign EQ   = eq_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (WIDTH=8).
// A vector table plus hand-built multi-cycle sequences; expected results
// and their completion cycle go into a scoreboard queue at stimulus time.
module tb_serial_mag_comparator;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a_in = 8'h00;
   logic [W-1:0] b_in = 8'h00;
   logic         signed_mode = 1'b0;
   logic         busy, done, GT, LT, EQ;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic res_valid = 1'b0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sgn;
      logic [2:0]   res;   // {GT,LT,EQ}
      int           lat;
   } vec_t;

   typedef struct {
      logic [2:0] res;
      int         cyc;
   } sb_t;

   vec_t vecs[12];
   sb_t  sb_q[$];
   sb_t  mon_e;

   serial_mag_comparator #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
      .signed_mode(signed_mode), .busy(busy), .done(done),
      .GT(GT), .LT(LT), .EQ(EQ)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got done=1 expected no pulse (cycle %0d)", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("result", {29'd0, GT, LT, EQ}, {29'd0, mon_e.res});
            chk("done_cycle", cyc, mon_e.cyc);
            res_valid = 1'b1;
         end
      end
      if (res_valid) chk("onehot", {31'd0, $onehot({GT, LT, EQ})}, 32'd1);
   end

   // One comparison from IDLE: drive, expect, wait bounded, check busy.
   task automatic run_vec(input vec_t v);
      bit got;
      @(negedge clk);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      a_in = v.a; b_in = v.b; signed_mode = v.sgn; start = 1'b1;
      sb_q.push_back('{res: v.res, cyc: cyc + v.lat});
      @(negedge clk);
      start = 1'b0;
      a_in = ~v.a;
      got = (done === 1'b1);
      chk("busy_run", {31'd0, busy}, 32'd1);
      for (int k = 0; k < W + 4 && !got; k++) begin
         @(negedge clk);
         got = (done === 1'b1);
         chk("busy_run", {31'd0, busy}, 32'd1);
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain(input int bound);
      for (int k = 0; k < bound && sb_q.size() != 0; k++) @(negedge clk);
      chk("sb_empty", sb_q.size(), 32'd0);
   endtask

   initial begin
      int n0;
      vecs[0]  = '{8'hA5, 8'h25, 1'b0, 3'b100, 2};
      vecs[1]  = '{8'h10, 8'h11, 1'b0, 3'b010, 9};
      vecs[2]  = '{8'h3C, 8'h3C, 1'b0, 3'b001, 9};
      vecs[3]  = '{8'h80, 8'h01, 1'b1, 3'b010, 2};
      vecs[4]  = '{8'h80, 8'h01, 1'b0, 3'b100, 2};
      vecs[5]  = '{8'h00, 8'hFF, 1'b1, 3'b100, 2};
      vecs[6]  = '{8'h7F, 8'h7E, 1'b1, 3'b100, 9};
      vecs[7]  = '{8'hFE, 8'hFF, 1'b1, 3'b010, 9};
      vecs[8]  = '{8'h00, 8'h00, 1'b1, 3'b001, 9};
      vecs[9]  = '{8'h12, 8'h1A, 1'b0, 3'b010, 6};
      vecs[10] = '{8'hF0, 8'hE0, 1'b0, 3'b100, 5};
      vecs[11] = '{8'h81, 8'hFF, 1'b1, 3'b010, 3};

      // Reset with start high: start must be ignored, outputs cleared.
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_res", {29'd0, GT, LT, EQ}, 32'd0);
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 12; i++) run_vec(vecs[i]);
      wait_drain(4);

      // Operands and start change mid-scan: original capture must win.
      @(negedge clk);
      a_in = 8'h10; b_in = 8'h11; signed_mode = 1'b0; start = 1'b1;
      sb_q.push_back('{res: 3'b010, cyc: cyc + 9});
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a_in = 8'hFF; b_in = 8'h00; signed_mode = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drain(20);
      repeat (4) @(negedge clk);

      // Held start: one accept every 3 cycles, GT each time.
      a_in = 8'hFF; b_in = 8'h7F; signed_mode = 1'b0; start = 1'b1;
      n0 = cyc;
      for (int k = 0; k < 10; k++) sb_q.push_back('{res: 3'b100, cyc: n0 + 3 * k + 2});
      repeat (30) @(negedge clk);
      start = 1'b0;
      wait_drain(6);
      repeat (3) @(negedge clk);

      // Reset in the 4th scan cycle of an equal compare: no done, outputs zero.
      a_in = 8'h3C; b_in = 8'h3C; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("scan_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      res_valid = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_res", {29'd0, GT, LT, EQ}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_idle", {31'd0, busy}, 32'd0);
      chk("sb_final", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: start  in  1  request a comparison; sampled only in IDLE.
REQ-005 Port: a_in  in  WIDTH  operand A; captured on an accepted start.
REQ-006 Port: b_in  in  WIDTH  operand B; captured on an accepted start.
REQ-007 Port: signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; captured on an accepted start.
REQ-008 Port: busy  out  1  high whenever the state is not IDLE.
REQ-009 Port: done  out  1  one-cycle pulse, high in the DONE cycle.
REQ-010 Port: GT  out  1  result A > B; registered.
REQ-011 Port: LT  out  1  result A < B; registered.
REQ-012 Port: EQ  out  1  result A == B; registered; GT/LT/EQ drive the downstream comparator_out bus.

Function
REQ-013 FSM states SHALL be IDLE, SCAN and DONE, with a bit-index counter of clog2(WIDTH) bits.
REQ-014 IDLE with start=1: capture a_in, b_in and signed_mode; set idx=WIDTH-1; go to SCAN.
REQ-015 IDLE with start=0: remain in IDLE; hold all outputs.
REQ-016 SCAN: compare the captured bits A[idx] and B[idx], one bit per cycle, MSB first.
REQ-017 SCAN with bits differing: decide the result and go to DONE.
  - unsigned mode: A[idx]=1 means GT, else LT.
  - signed mode at idx=WIDTH-1: the sense is inverted (A[idx]=1 means LT).
REQ-018 SCAN with bits equal and idx=0: result is EQ; go to DONE.
REQ-019 SCAN with bits equal and idx>0: decrement idx; stay in SCAN.
REQ-020 GT/LT/EQ SHALL update on the edge entering DONE, valid in the same cycle as done=1.
REQ-021 GT/LT/EQ SHALL hold until the next DONE; after the first result exactly one of them is high.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-023 Latency: with start accepted in cycle n and the highest differing bit at position p, done SHALL be high in cycle n+WIDTH-p+1.
  - EQ result: done in cycle n+WIDTH+1.
  - Minimum latency is n+2; maximum is n+WIDTH+1.
REQ-024 start in SCAN or DONE SHALL be ignored, with no queuing.
  - A start held high is accepted in the next IDLE cycle.
  - Back-to-back period is therefore (latency+1) cycles.
REQ-025 Changes on a_in, b_in or signed_mode after capture SHALL NOT affect the comparison in progress.

Reset
REQ-026 With rst=1 at a clock edge, the next state is IDLE with idx=0, busy=0, done=0, GT=0, LT=0, EQ=0.
REQ-027 rst SHALL take priority over start and over any SCAN/DONE transition; a comparison interrupted by reset produces no done pulse.
REQ-028 start is ignored while rst=1; the first legal start is the first cycle with rst=0.

Verification
REQ-029 WIDTH=8, unsigned, A=0xA5, B=0x25 -> done in n+2, GT=1 LT=0 EQ=0, busy high in n+1..n+2.
REQ-030 A=0x10, B=0x11, unsigned -> done in n+9, LT=1; then A=B=0x3C -> done in n+9, EQ=1 only.
REQ-031 A=0x80, B=0x01, signed_mode=1 -> LT=1 in n+2; same operands with signed_mode=0 -> GT=1.
REQ-032 Operands changed and start pulsed during SCAN -> result reflects the originally captured operands; exactly one done pulse.
REQ-033 rst asserted in the 4th SCAN cycle of an A=B compare -> the next cycle has busy=0, GT=LT=EQ=0, and no done pulse ever appears.
REQ-034 start held high for 30 cycles with A=0xFF, B=0x7F -> done every 3 cycles, GT=1 each time, and GT/LT/EQ one-hot throughout.
